// File: rtl/bsg_credit_counter_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_credit_counter_multi                                                 |
// | Single-clock, per-channel credit counter with token decimation,          |
// | infinite-credit mode, saturation and sticky error flags.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bsg_credit_counter_multi #(
  parameter int els_p                           = 2,
  parameter int max_credits_p                   = 8,
  parameter int lg_credit_to_token_decimation_p = 2,
  localparam int cnt_width_lp                   = $clog2(max_credits_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [els_p-1:0]                token_i,
  input  logic [els_p-1:0]                dec_credit_i,
  input  logic [els_p-1:0]                infinite_credits_i,
  output logic [els_p-1:0]                credits_avail_o,
  output logic [els_p*cnt_width_lp-1:0]   credits_o,
  output logic [els_p-1:0]                error_o
);

  localparam int tokens_credits_lp = 1 << lg_credit_to_token_decimation_p;

  // One extra bit lets cnt + inc be compared against the ceiling without wrap.
  localparam logic [cnt_width_lp:0] inc_wide_lp = (cnt_width_lp+1)'(tokens_credits_lp);
  localparam logic [cnt_width_lp:0] max_wide_lp = (cnt_width_lp+1)'(max_credits_p);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_credits_p);

  if (els_p < 1) begin : g_chk_els
    $fatal(1, "bsg_credit_counter_multi: els_p must be >= 1");
  end
  if (max_credits_p < tokens_credits_lp) begin : g_chk_min
    $fatal(1, "bsg_credit_counter_multi: max_credits_p must be >= 2^lg");
  end
  if ((max_credits_p % tokens_credits_lp) != 0) begin : g_chk_mod
    $fatal(1, "bsg_credit_counter_multi: max_credits_p must be a multiple of 2^lg");
  end

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [cnt_width_lp:0]   inc, sum;
    logic                    dec_ok, underflow, overflow;

    always_comb begin
      inc       = token_i[i] ? inc_wide_lp : '0;
      // A token arriving in the same cycle funds a decrement taken at zero.
      dec_ok    = dec_credit_i[i] & ~infinite_credits_i[i] & ((cnt_q != '0) | token_i[i]);
      underflow = dec_credit_i[i] & ~infinite_credits_i[i] & (cnt_q == '0) & ~token_i[i];
      sum       = {1'b0, cnt_q} + inc - {{cnt_width_lp{1'b0}}, dec_ok};
      overflow  = (sum > max_wide_lp);
      cnt_d     = overflow ? max_cnt_lp : sum[cnt_width_lp-1:0];
      err_d     = err_q | underflow | overflow;
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_q <= max_cnt_lp;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign credits_o[i*cnt_width_lp +: cnt_width_lp] = cnt_q;
    assign credits_avail_o[i] = infinite_credits_i[i] | (cnt_q != '0);
    assign error_o[i]         = err_q;
  end

endmodule
`default_nettype wire
